// File: rtl/stopwatch_digits.sv
// Four-digit BCD stopwatch: synchronized buttons, IDLE/RUN/PAUSE control and a sticky rollover flag.
// Define STOPWATCH_LAP_HOLD_EN to let the lap button freeze the displayed value.

module stopwatch_digits #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic [15:0] digits,
  output logic        running,
  output logic        wrapped
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  if ((CLK_HZ % TICK_HZ) != 0 || DIV < 2) begin : g_div_check
    $error("stopwatch_digits: CLK_HZ/TICK_HZ must be an integer >= 2");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // Adds one to a 4-digit BCD value; the top bit is the carry out of the last digit.
  function automatic logic [16:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c           = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  // ---------------------------------------------------------------------------
  // Button synchronizers and rising-edge detectors: {lap, clear, start_stop}
  // ---------------------------------------------------------------------------
  logic [2:0] btn;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] prev;
  logic [2:0] press;
  logic [1:0] settle;
  logic       ss_press;
  logic       clr_press;
  logic       lap_press;

  assign btn = {lap, clear, start_stop};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1  <= '0;
      sync2  <= '0;
      prev   <= '0;
      settle <= '0;
    end else begin
      // NOTE: non-blocking assignments make each stage capture the previous
      // stage's old value, so the chain really is three distinct flops.
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
      if (settle != 2'd3) settle <= settle + 2'd1;
    end
  end

  // The chain restarts from zero after reset; the settle mask keeps a button
  // that was already held from looking like a fresh press while it refills.
  assign press     = (settle == 2'd3) ? (sync2 & ~prev) : 3'b000;
  assign ss_press  = press[0];
  assign clr_press = press[1];
  assign lap_press = press[2];

  // ---------------------------------------------------------------------------
  // Control and count datapath
  // ---------------------------------------------------------------------------
  state_t        state;
  logic [PW-1:0] presc;
  logic [15:0]   count;
  logic [15:0]   count_inc;
  logic [15:0]   count_next;
  logic          carry;
  logic          tick;
  logic          go_idle;

  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no
    // path can leave one unassigned and infer a latch.
    tick             = (state == RUN) && (presc == PRESC_LAST);
    go_idle          = (state == PAUSE) && clr_press;
    {carry, count_inc} = bcd_inc(count);
    count_next       = count;
    if (go_idle) begin
      count_next = '0;
    end else if (tick) begin
      count_next = count_inc;
    end
  end

`ifdef STOPWATCH_LAP_HOLD_EN
  logic hold;
  logic hold_next;

  always_comb begin
    hold_next = hold;
    if (go_idle) begin
      hold_next = 1'b0;
    end else if (lap_press && (state != IDLE)) begin
      hold_next = ~hold;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold <= 1'b0;
    end else begin
      hold <= hold_next;
    end
  end
`else
  logic unused_lap;
  assign unused_lap = lap_press;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      presc   <= '0;
      count   <= '0;
      digits  <= '0;
      running <= 1'b0;
      wrapped <= 1'b0;
    end else begin
      count <= count_next;
`ifdef STOPWATCH_LAP_HOLD_EN
      digits <= hold_next ? digits : count_next;
`else
      digits <= count_next;
`endif

      // Prescaler only moves in RUN, so a pause resumes at the same phase.
      if (tick || go_idle) begin
        presc <= '0;
      end else if (state == RUN) begin
        presc <= presc + PW'(1);
      end

      if (tick && carry) begin
        wrapped <= 1'b1;
      end else if (go_idle) begin
        wrapped <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (ss_press) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (ss_press) begin
            state   <= PAUSE;
            running <= 1'b0;
          end
        end
        PAUSE: begin
          if (clr_press) begin
            state   <= IDLE;
            running <= 1'b0;
          end else if (ss_press) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_digits.sv
// Scoreboard bench for stopwatch_digits: a DIV=10 instance for control/timing and a DIV=2
// instance that runs to the 9999->0000 rollover. Expectations are queued per clock edge.

module tb_stopwatch_digits;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  bm;            // main instance {lap, clear, start_stop}
  logic [1:0]  bw;            // wrap instance {clear, start_stop}
  logic [15:0] m_digits, w_digits;
  logic        m_running, w_running, m_wrapped, w_wrapped;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int max_at = 0;

  typedef struct {
    int          at;
    bit          sel;
    string       name;
    logic [15:0] d;
    logic        r;
    logic        w;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  stopwatch_digits #(.CLK_HZ(10), .TICK_HZ(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .start_stop(bm[0]), .clear(bm[1]), .lap(bm[2]),
    .digits(m_digits), .running(m_running), .wrapped(m_wrapped)
  );

  stopwatch_digits #(.CLK_HZ(2), .TICK_HZ(1)) dut_wrap (
    .clk(clk), .reset_n(reset_n),
    .start_stop(bw[0]), .clear(bw[1]), .lap(1'b0),
    .digits(w_digits), .running(w_running), .wrapped(w_wrapped)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got digits=%h running=%b wrapped=%b, want digits=%h running=%b wrapped=%b",
               name, cyc, act[17:2], act[1], act[0], exp[17:2], exp[1], exp[0]);
    end
  endtask

  // Expected state after clock edge 'at', kept sorted by edge number.
  function automatic void push_exp(input int at, input bit sel, input string name,
                                   input logic [15:0] d, input logic r, input logic w);
    exp_t e;
    int   i;
    e.at = at; e.sel = sel; e.name = name; e.d = d; e.r = r; e.w = w;
    i = q.size();
    while (i > 0 && q[i-1].at > at) i--;
    q.insert(i, e);
    if (at > max_at) max_at = at;
  endfunction

  // Monitor: compares on the falling edge, away from the sampling edge.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      mon_e = q.pop_front();
      if (mon_e.at != cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for edge %0d reached monitor at edge %0d", mon_e.name, mon_e.at, cyc);
      end else if (mon_e.sel) begin
        check(mon_e.name, {w_digits, w_running, w_wrapped}, {mon_e.d, mon_e.r, mon_e.w});
      end else begin
        check(mon_e.name, {m_digits, m_running, m_wrapped}, {mon_e.d, mon_e.r, mon_e.w});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) step(1);
  endtask

  // Raise the buttons for two edges then drop them; returns on the edge the press acts.
  task automatic press(input bit sel, input logic [2:0] mask);
    if (sel) bw = mask[1:0];
    else     bm = mask;
    step(2);
    if (sel) bw = 2'b00;
    else     bm = 3'b000;
    step(1);
  endtask

  int w, r, p, s, c1, p2, c2, e1, e2, e3, e4, l, m, wp, cl;
  logic [15:0] lap_exp;

  initial begin
    bm      = 3'b111;
    bw      = 2'b11;
    reset_n = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      push_exp(k, 1'b0, "reset_main", 16'h0000, 1'b0, 1'b0);
      push_exp(k, 1'b1, "reset_wrap", 16'h0000, 1'b0, 1'b0);
    end
    step(2);
    reset_n = 1'b1;
    step(4);                     // buttons still held across release
    bm = 3'b000;
    bw = 2'b00;
    step(4);

    // Wrap instance: DIV=2, count k after edge w+2k.
    w = cyc + 3;
    push_exp(w - 1,     1'b1, "wrap_pre_start", 16'h0000, 1'b0, 1'b0);
    push_exp(w,         1'b1, "wrap_run",       16'h0000, 1'b1, 1'b0);
    push_exp(w + 19998, 1'b1, "wrap_9999",      16'h9999, 1'b1, 1'b0);
    push_exp(w + 19999, 1'b1, "wrap_9999_hold", 16'h9999, 1'b1, 1'b0);
    push_exp(w + 20000, 1'b1, "wrap_rollover",  16'h0000, 1'b1, 1'b1);
    push_exp(w + 20002, 1'b1, "wrap_continue",  16'h0001, 1'b1, 1'b1);
    press(1'b1, 3'b001);

    // Start: running on the 3rd edge, ticks every 10 edges.
    r = cyc + 3;
    push_exp(r - 1,  1'b0, "start_not_yet", 16'h0000, 1'b0, 1'b0);
    push_exp(r,      1'b0, "start_running", 16'h0000, 1'b1, 1'b0);
    push_exp(r + 9,  1'b0, "pre_tick1",     16'h0000, 1'b1, 1'b0);
    push_exp(r + 10, 1'b0, "tick1",         16'h0001, 1'b1, 1'b0);
    push_exp(r + 19, 1'b0, "pre_tick2",     16'h0001, 1'b1, 1'b0);
    push_exp(r + 20, 1'b0, "tick2",         16'h0002, 1'b1, 1'b0);
    press(1'b0, 3'b001);

    // Pause 25 edges into RUN (prescaler at 5), hold, resume.
    wait_until(r + 22);
    p = cyc + 3;
    push_exp(p - 1, 1'b0, "pre_pause", 16'h0002, 1'b1, 1'b0);
    for (int k = p; k <= p + 42; k++) push_exp(k, 1'b0, "pause_hold", 16'h0002, 1'b0, 1'b0);
    press(1'b0, 3'b001);
    wait_until(p + 40);
    s = cyc + 3;
    push_exp(s,     1'b0, "resume",          16'h0002, 1'b1, 1'b0);
    push_exp(s + 4, 1'b0, "resume_pre_tick", 16'h0002, 1'b1, 1'b0);
    push_exp(s + 5, 1'b0, "resume_tick",     16'h0003, 1'b1, 1'b0);
    press(1'b0, 3'b001);

    // Clear in RUN is ignored.
    wait_until(s + 6);
    c1 = cyc + 3;
    for (int k = c1; k <= c1 + 3; k++) push_exp(k, 1'b0, "clear_in_run", 16'h0003, 1'b1, 1'b0);
    push_exp(s + 15, 1'b0, "run_after_clear", 16'h0004, 1'b1, 1'b0);
    press(1'b0, 3'b010);

    // Pause, then clear in PAUSE returns to IDLE.
    wait_until(s + 16);
    p2 = cyc + 3;
    push_exp(p2, 1'b0, "pause2", 16'h0004, 1'b0, 1'b0);
    press(1'b0, 3'b001);
    wait_until(p2 + 2);
    c2 = cyc + 3;
    push_exp(c2 - 1, 1'b0, "pre_clear",      16'h0004, 1'b0, 1'b0);
    push_exp(c2,     1'b0, "clear_in_pause", 16'h0000, 1'b0, 1'b0);
    push_exp(c2 + 5, 1'b0, "idle_stays",     16'h0000, 1'b0, 1'b0);
    press(1'b0, 3'b010);
    wait_until(c2 + 6);

    // Simultaneous start_stop + clear in each state.
    e1 = cyc + 3;
    push_exp(e1, 1'b0, "both_in_idle", 16'h0000, 1'b1, 1'b0);
    press(1'b0, 3'b011);
    e2 = cyc + 3;
    push_exp(e2, 1'b0, "both_in_run", 16'h0000, 1'b0, 1'b0);
    press(1'b0, 3'b011);
    e3 = cyc + 3;
    push_exp(e3,     1'b0, "both_in_pause", 16'h0000, 1'b0, 1'b0);
    push_exp(e3 + 5, 1'b0, "both_idle_hold", 16'h0000, 1'b0, 1'b0);
    press(1'b0, 3'b011);
    wait_until(e3 + 6);

    // Restart from IDLE: prescaler was zeroed, so first tick is 10 edges on.
    e4 = cyc + 3;
    push_exp(e4,      1'b0, "restart",      16'h0000, 1'b1, 1'b0);
    push_exp(e4 + 9,  1'b0, "presc_zeroed", 16'h0000, 1'b1, 1'b0);
    push_exp(e4 + 10, 1'b0, "restart_tick", 16'h0001, 1'b1, 1'b0);
    press(1'b0, 3'b001);

    // Lap at 0003, 30 edges later lap again (count 6 by then).
    wait_until(e4 + 31);
    l = cyc + 3;
    m = l + 33;
    for (int k = l; k <= m + 3; k++) begin
      lap_exp = 16'((k - e4) / 10);
`ifdef STOPWATCH_LAP_HOLD_EN
      if (k < m) lap_exp = 16'h0003;
`endif
      push_exp(k, 1'b0, "lap", lap_exp, 1'b1, 1'b0);
    end
    press(1'b0, 3'b100);
    wait_until(l + 30);
    press(1'b0, 3'b100);

    // Wrap instance: wrapped stays set through pause, clears with clear.
    wait_until(w + 20010);
    wp = cyc + 3;
    push_exp(wp,     1'b1, "wrap_pause",     16'h0006, 1'b0, 1'b1);
    push_exp(wp + 2, 1'b1, "wrapped_sticky", 16'h0006, 1'b0, 1'b1);
    press(1'b1, 3'b001);
    wait_until(wp + 2);
    cl = cyc + 3;
    push_exp(cl - 1, 1'b1, "wrap_pre_clear", 16'h0006, 1'b0, 1'b1);
    push_exp(cl,     1'b1, "wrap_clear",     16'h0000, 1'b0, 1'b0);
    press(1'b1, 3'b010);

    wait_until(max_at + 1);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drained: got %0d pending expectations, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
